usb_tx: RTL and testbench
=========================

USB_TX -- requirements
Module: usb_tx

Interface
REQ-001 SHALL have ports: clk48  in  1  48 MHz clock, sole clock; all state on its rising edge.
REQ-002 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have: start  in  1  request to transmit; sampled only while busy=0.
REQ-004 SHALL have: length  in  10  packet byte count including PID; latched on accepted start.
REQ-005 SHALL have: append_crc  in  1  request CRC16 append; latched on accepted start.
REQ-006 SHALL have: buffer_address  out  8  word address into the 1024-byte USB packet buffer.
REQ-007 SHALL have: buffer_read_value  in  32  word at buffer_address, valid one clk48 after the address.
REQ-008 SHALL have: usb_d_p_out, usb_d_n_out  out  1 each  line drive levels.
REQ-009 SHALL have: usb_oe  out  1  1 = drive bus.
REQ-010 SHALL have: busy  out  1  transmission in progress.
REQ-011 SHALL have: done  out  1  one-cycle completion pulse.

Function
REQ-012 SHALL transmit at full speed: one bit time = 4 clk48 cycles, held constant across the whole packet.
REQ-013 SHALL accept start when busy=0 and length!=0; start with length=0 SHALL be ignored (no busy, no done).
REQ-014 SHALL, on start accepted at edge N, drive usb_oe=1, busy=1 and the first SYNC bit from cycle N+1.
REQ-015 SHALL use states IDLE -> SYNC -> DATA -> [CRC] -> EOP_SE0 -> EOP_J -> IDLE.
REQ-016 SYNC SHALL send the 8 bits 0000_0001 (LSB first), giving line states KJKJKJKK.
REQ-017 Byte n SHALL come from word n/4, bits [8*(n%4)+7 : 8*(n%4)] (little-endian); bits sent LSB first.
REQ-018 SHALL prefetch each word so that no bit time is stretched; buffer_address SHALL step 0,1,2,... once per 4 bytes.
REQ-019 NRZI: data 0 toggles the line, data 1 holds; J = (d_p=1,d_n=0), K = (0,1); the line starts from J.
REQ-020 Bit stuffing: after six consecutive 1s, a 0 SHALL be inserted; the run count includes SYNC's final 1, continues across byte and CRC boundaries, and ends at EOP.
REQ-021 EOP SHALL be SE0 (0,0) for 2 bit times, then J for 1 bit time.
REQ-022 After EOP_J the block SHALL set usb_oe=0, busy=0, and done=1 for exactly one cycle.
REQ-023 start in the done cycle SHALL be accepted.
REQ-024 start while busy=1 SHALL be ignored, and length and append_crc SHALL NOT be re-latched.
REQ-025 Idle outputs SHALL be usb_d_p_out=1, usb_d_n_out=0, usb_oe=0.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE: usb_oe=0, usb_d_p_out=1, usb_d_n_out=0, busy=0, done=0, buffer_address=0, stuffing and CRC state cleared.
REQ-027 Reset mid-packet SHALL abort with no done pulse; a start after release SHALL transmit a complete packet.

Configuration
REQ-028 Macro USB_TX_CRC16_EN defined: when append_crc=1, a CRC16 over bytes 1..length-1 SHALL be sent after DATA, with parameters:
- polynomial 0x8005, reflected;
- init 0xFFFF, final complement;
- LSB first, stuffed as data;
- empty payload yields 0x0000.
REQ-029 Macro USB_TX_CRC16_EN undefined: append_crc SHALL be ignored, the CRC state SHALL not exist, and packets SHALL end after the last buffer byte.

Verification
REQ-030 ACK: word0=0x000000D2, length=1, append_crc=0.
- Expect SYNC KJKJKJKK, then PID bits 0,1,0,0,1,0,1,1 NRZI-encoded.
- Expect SE0 8 cycles, J 4 cycles; busy high 76 cycles, then done.
REQ-031 Stuffing: bytes 0xC3,0xFF, length=2.
- Expect exactly one stuffed 0 after the 6th consecutive 1.
- Expect busy 112 cycles.
REQ-032 CRC (USB_TX_CRC16_EN): word0=0x4B, length=1, append_crc=1.
- Expect 16 zero-data bits (line toggles every bit time) before EOP.
- Expect busy 140 cycles.
REQ-033 Ordering: length=6, word0=0x04030201, word1=0x0605.
- Expect bytes 01,02,03,04,05,06 on the line.
- Expect buffer_address 0 then 1.
REQ-034 Reset: rst_n pulsed low during byte 1.
- Expect idle outputs in the same cycle and no done.
- Expect the next start to give a correct full packet.
REQ-035 Handshake:
- start while busy=1 -> no effect.
- start in the done cycle -> SYNC begins the next cycle.
- start with length=0 -> busy stays 0.

Source files
------------

// File: rtl/usb_tx.sv
// usb_tx: full-speed USB packet transmitter (SYNC, NRZI, bit stuffing, EOP) fed from a word buffer.
// Define USB_TX_CRC16_EN to build the optional CRC16 append stage.
module usb_tx (
  input  logic        clk48,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  length,
  input  logic        append_crc,
  output logic [7:0]  buffer_address,
  input  logic [31:0] buffer_read_value,
  output logic        usb_d_p_out,
  output logic        usb_d_n_out,
  output logic        usb_oe,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StData,
`ifdef USB_TX_CRC16_EN
    StCrc,
`endif
    StEopSe0,
    StEopJ
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [3:0]  bit_q, bit_d;
  logic [9:0]  byte_q, byte_d;
  logic [9:0]  len_q, len_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  addr_q, addr_d;
  logic [2:0]  ones_q, ones_d;
  logic        line_q, line_d;  // 1 = J, 0 = K
  logic        done_q, done_d;

  logic        send;
  logic        send_bit;
  logic        begin_byte;
  logic [9:0]  next_byte;
  logic [3:0]  bit_nx;
  logic [7:0]  cur_byte;

`ifdef USB_TX_CRC16_EN
  logic        crc_en_q, crc_en_d;
  logic [15:0] crc_q, crc_d;
  logic        crc_upd;
`else
  logic        unused_append_crc;
  assign unused_append_crc = append_crc;
`endif

  assign bit_nx   = bit_q + 4'd1;
  assign cur_byte = word_q[{byte_q[1:0], 3'b000} +: 8];

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    len_d      = len_q;
    word_d     = word_q;
    addr_d     = addr_q;
    ones_d     = ones_q;
    line_d     = line_q;
    done_d     = 1'b0;
    send       = 1'b0;
    send_bit   = 1'b0;
    begin_byte = 1'b0;
    next_byte  = 10'd0;
`ifdef USB_TX_CRC16_EN
    crc_en_d   = crc_en_q;
    crc_d      = crc_q;
    crc_upd    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        phase_d = 2'd0;
        if (start && length != 10'd0) begin
          state_d = StSync;
          len_d   = length;
          bit_d   = 4'd0;
          byte_d  = 10'd0;
          addr_d  = 8'd0;
          ones_d  = 3'd0;
          line_d  = 1'b0;  // first SYNC bit is a 0, so the line leaves J at once
`ifdef USB_TX_CRC16_EN
          crc_en_d = append_crc;
          crc_d    = 16'hFFFF;
`endif
        end
      end
      StEopSe0: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          if (bit_q[0]) begin
            state_d = StEopJ;
            bit_d   = 4'd0;
          end else begin
            bit_d = 4'd1;
          end
        end
      end
      StEopJ: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          state_d = StIdle;
          done_d  = 1'b1;
          line_d  = 1'b1;
        end
      end
      default: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          if (ones_q == 3'd6) begin
            // stuffed 0: toggle without advancing the bit position
            line_d = ~line_q;
            ones_d = 3'd0;
          end else if (state_q == StSync) begin
            if (bit_q[2:0] != 3'd7) begin
              bit_d    = bit_nx;
              send     = 1'b1;
              send_bit = (bit_q[2:0] == 3'd6);
            end else begin
              begin_byte = 1'b1;
              next_byte  = 10'd0;
            end
          end else if (state_q == StData) begin
            if (bit_q[2:0] != 3'd7) begin
              bit_d    = bit_nx;
              send     = 1'b1;
              send_bit = cur_byte[bit_nx[2:0]];
`ifdef USB_TX_CRC16_EN
              crc_upd  = (byte_q != 10'd0);
`endif
            end else if (byte_q + 10'd1 < len_q) begin
              begin_byte = 1'b1;
              next_byte  = byte_q + 10'd1;
            end
`ifdef USB_TX_CRC16_EN
            else if (crc_en_q) begin
              state_d  = StCrc;
              bit_d    = 4'd0;
              send     = 1'b1;
              send_bit = ~crc_q[0];
            end
`endif
            else begin
              state_d = StEopSe0;
              bit_d   = 4'd0;
              ones_d  = 3'd0;
            end
          end
`ifdef USB_TX_CRC16_EN
          else if (bit_q != 4'd15) begin
            bit_d    = bit_nx;
            send     = 1'b1;
            send_bit = ~crc_q[bit_nx];
          end else begin
            state_d = StEopSe0;
            bit_d   = 4'd0;
            ones_d  = 3'd0;
          end
`endif
        end
      end
    endcase

    if (begin_byte) begin
      state_d = StData;
      byte_d  = next_byte;
      bit_d   = 4'd0;
      send    = 1'b1;
      if (next_byte[1:0] == 2'd0) begin
        // word was prefetched at addr_q; point at the next one only if it is needed
        word_d   = buffer_read_value;
        send_bit = buffer_read_value[0];
        if ({1'b0, next_byte} + 11'd4 < {1'b0, len_q}) begin
          addr_d = addr_q + 8'd1;
        end
      end else begin
        send_bit = word_q[{next_byte[1:0], 3'b000}];
      end
`ifdef USB_TX_CRC16_EN
      crc_upd = (next_byte != 10'd0);
`endif
    end

    if (send) begin
      line_d = send_bit ? line_q : ~line_q;
      ones_d = send_bit ? ones_q + 3'd1 : 3'd0;
    end

`ifdef USB_TX_CRC16_EN
    if (crc_upd) begin
      crc_d = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ send_bit) ? 16'hA001 : 16'h0000);
    end
`endif
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      phase_q  <= 2'd0;
      bit_q    <= 4'd0;
      byte_q   <= 10'd0;
      len_q    <= 10'd0;
      word_q   <= 32'd0;
      addr_q   <= 8'd0;
      ones_q   <= 3'd0;
      line_q   <= 1'b1;
      done_q   <= 1'b0;
`ifdef USB_TX_CRC16_EN
      crc_en_q <= 1'b0;
      crc_q    <= 16'd0;
`endif
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      len_q    <= len_d;
      word_q   <= word_d;
      addr_q   <= addr_d;
      ones_q   <= ones_d;
      line_q   <= line_d;
      done_q   <= done_d;
`ifdef USB_TX_CRC16_EN
      crc_en_q <= crc_en_d;
      crc_q    <= crc_d;
`endif
    end
  end

  assign busy           = (state_q != StIdle);
  assign usb_oe         = busy;
  assign done           = done_q;
  assign buffer_address = addr_q;

  always_comb begin
    usb_d_p_out = 1'b1;
    usb_d_n_out = 1'b0;
    unique case (state_q)
      StIdle, StEopJ: begin
        usb_d_p_out = 1'b1;
        usb_d_n_out = 1'b0;
      end
      StEopSe0: begin
        usb_d_p_out = 1'b0;
        usb_d_n_out = 1'b0;
      end
      default: begin
        usb_d_p_out = line_q;
        usb_d_n_out = ~line_q;
      end
    endcase
  end

endmodule

// File: tb/tb_usb_tx.sv
// Scoreboard bench for usb_tx: a bit-level packet model predicts the line, a monitor compares.
module tb_usb_tx;

  logic        clk48;
  logic        rst_n;
  logic        start;
  logic [9:0]  length;
  logic        append_crc;
  logic [7:0]  buffer_address;
  logic [31:0] buffer_read_value;
  logic        usb_d_p_out;
  logic        usb_d_n_out;
  logic        usb_oe;
  logic        busy;
  logic        done;

  usb_tx dut (
    .clk48             (clk48),
    .rst_n             (rst_n),
    .start             (start),
    .length            (length),
    .append_crc        (append_crc),
    .buffer_address    (buffer_address),
    .buffer_read_value (buffer_read_value),
    .usb_d_p_out       (usb_d_p_out),
    .usb_d_n_out       (usb_d_n_out),
    .usb_oe            (usb_oe),
    .busy              (busy),
    .done              (done)
  );

`ifdef USB_TX_CRC16_EN
  localparam bit CrcBuilt = 1'b1;
`else
  localparam bit CrcBuilt = 1'b0;
`endif
  localparam logic [2:0] SymJ   = 3'b110;
  localparam logic [2:0] SymK   = 3'b101;
  localparam logic [2:0] SymSe0 = 3'b100;

  initial begin
    clk48 = 1'b0;
    forever #5 clk48 = ~clk48;
  end

  // Packet buffer, byte addressed; read port returns the word one clock after the address.
  logic [7:0] mem_b [1024];
  always @(posedge clk48) begin
    buffer_read_value <= {mem_b[{buffer_address, 2'd3}], mem_b[{buffer_address, 2'd2}],
                          mem_b[{buffer_address, 2'd1}], mem_b[{buffer_address, 2'd0}]};
  end

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, want, want);
  endfunction

  // Scoreboard queues: per-cycle line symbols, packet length in cycles, highest word address.
  logic [2:0] exp_sym[$];
  int         exp_len[$];
  int         exp_maxa[$];

  task automatic model_push(input int len, input bit use_crc);
    bit          raw[$];
    bit          stf[$];
    int          run;
    logic        lvl;
    logic [15:0] c;
    for (int i = 0; i < 7; i++) raw.push_back(1'b0);
    raw.push_back(1'b1);
    for (int n = 0; n < len; n++)
      for (int i = 0; i < 8; i++) raw.push_back(mem_b[n][i]);
    if (use_crc && CrcBuilt) begin
      c = 16'hFFFF;
      for (int n = 1; n < len; n++)
        for (int i = 0; i < 8; i++)
          c = (c[0] ^ mem_b[n][i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      c = ~c;
      for (int i = 0; i < 16; i++) raw.push_back(c[i]);
    end
    run = 0;
    foreach (raw[k]) begin
      stf.push_back(raw[k]);
      run = raw[k] ? run + 1 : 0;
      if (run == 6) begin
        stf.push_back(1'b0);
        run = 0;
      end
    end
    lvl = 1'b1;
    foreach (stf[k]) begin
      if (!stf[k]) lvl = ~lvl;
      repeat (4) exp_sym.push_back(lvl ? SymJ : SymK);
    end
    repeat (8) exp_sym.push_back(SymSe0);
    repeat (4) exp_sym.push_back(SymJ);
    exp_len.push_back(stf.size() * 4 + 12);
    exp_maxa.push_back((len - 1) / 4);
  endtask

  // Monitor: collects the line while busy, scores the packet on the done pulse.
  logic [2:0] act[$];
  int         first_a, max_a, last_busy;
  bit         prev_done;
  initial begin
    int n, ma, mism;
    logic [2:0] es;
    prev_done = 1'b0;
    last_busy = 0;
    forever begin
      @(negedge clk48);
      if (!rst_n) begin
        act.delete();
        prev_done = 1'b0;
      end else begin
        if (busy) begin
          if (act.size() == 0) begin
            first_a = int'(buffer_address);
            max_a   = int'(buffer_address);
          end else if (int'(buffer_address) > max_a) begin
            max_a = int'(buffer_address);
          end
          act.push_back({usb_oe, usb_d_p_out, usb_d_n_out});
        end
        if (done) begin
          check("done_single_cycle", int'(prev_done), 0);
          check("done_idle_lines", int'({busy, usb_oe, usb_d_p_out, usb_d_n_out}), 4'b0010);
          check("done_has_pending_packet", int'(exp_len.size() != 0), 1);
          if (exp_len.size() != 0) begin
            n  = exp_len.pop_front();
            ma = exp_maxa.pop_front();
            last_busy = act.size();
            check("packet_cycles", act.size(), n);
            mism = -1;
            for (int k = 0; k < n; k++) begin
              es = exp_sym.pop_front();
              if (mism < 0 && (k >= act.size() || act[k] !== es)) mism = k;
            end
            check("packet_first_bad_cycle", mism, -1);
            check("first_buffer_address", first_a, 0);
            check("max_buffer_address", max_a, ma);
          end
          act.delete();
        end
        prev_done = done;
      end
    end
  end

  task automatic issue(input int len, input bit crc, input bit expect_pkt);
    @(negedge clk48);
    length     = 10'(len);
    append_crc = crc;
    start      = 1'b1;
    if (expect_pkt) model_push(len, crc);
    @(posedge clk48);
    #1;
    start      = 1'b0;
    length     = 10'($urandom);
    append_crc = 1'($urandom);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk48);
      k++;
    end while (!done && k < 3000);
    check({name, "_done_seen"}, int'(done), 1);
  endtask

  initial begin
    bit seen;
    int len;
    rst_n      = 1'b0;
    start      = 1'b0;
    length     = 10'd0;
    append_crc = 1'b0;
    for (int i = 0; i < 1024; i++) mem_b[i] = 8'h00;
    #1;
    check("reset_outputs", int'({busy, usb_oe, usb_d_p_out, usb_d_n_out, done}), 5'b00100);
    check("reset_address", int'(buffer_address), 0);
    #20;
    @(negedge clk48);
    rst_n = 1'b1;

    // ACK handshake packet
    mem_b[0] = 8'hD2;
    issue(1, 1'b0, 1'b1);
    wait_done("ack");
    @(posedge clk48);
    #1;
    check("ack_busy_cycles", last_busy, 76);

    // one stuffed bit inside 0xFF
    mem_b[0] = 8'hC3;
    mem_b[1] = 8'hFF;
    issue(2, 1'b0, 1'b1);
    wait_done("stuff");
    @(posedge clk48);
    #1;
    check("stuff_busy_cycles", last_busy, 112);

    // CRC over an empty payload
    mem_b[0] = 8'h4B;
    issue(1, 1'b1, 1'b1);
    wait_done("crc");
    @(posedge clk48);
    #1;
    check("crc_busy_cycles", last_busy, CrcBuilt ? 140 : 76);

    // byte ordering across two words
    for (int i = 0; i < 6; i++) mem_b[i] = 8'(i + 1);
    issue(6, 1'b0, 1'b1);
    wait_done("order");

    // start while busy is ignored and does not re-latch
    issue(6, 1'b0, 1'b1);
    repeat (40) @(negedge clk48);
    length     = 10'd3;
    append_crc = 1'b1;
    start      = 1'b1;
    @(posedge clk48);
    #1;
    start = 1'b0;
    wait_done("busy_ignore");

    // start in the done cycle
    mem_b[0] = 8'hD2;
    issue(1, 1'b0, 1'b1);
    wait_done("pre_done_start");
    length     = 10'd1;
    append_crc = 1'b0;
    start      = 1'b1;
    model_push(1, 1'b0);
    @(posedge clk48);
    #1;
    start = 1'b0;
    check("done_cycle_start_sync", int'({busy, usb_oe, usb_d_p_out, usb_d_n_out}), 4'b1101);
    wait_done("done_start");

    // length 0 is ignored
    issue(0, 1'b0, 1'b0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk48);
      if (busy || done) seen = 1'b1;
    end
    check("len0_ignored", int'(seen), 0);

    // reset during byte 1 aborts silently
    for (int i = 0; i < 4; i++) mem_b[i] = 8'(8'hA0 + i);
    issue(4, 1'b0, 1'b0);
    repeat (70) @(negedge clk48);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_abort_outputs", int'({busy, usb_oe, usb_d_p_out, usb_d_n_out, done}), 5'b00100);
    check("reset_abort_address", int'(buffer_address), 0);
    @(negedge clk48);
    @(negedge clk48);
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (200) begin
      @(negedge clk48);
      if (busy || done) seen = 1'b1;
    end
    check("reset_abort_quiet", int'(seen), 0);
    issue(4, 1'b0, 1'b1);
    wait_done("post_reset");

    // randomized packets, biased toward 0xFF to exercise stuffing
    for (int r = 0; r < 20; r++) begin
      len = int'($urandom_range(1, 12));
      for (int n = 0; n < len; n++)
        mem_b[n] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      issue(len, 1'($urandom_range(0, 1)), 1'b1);
      wait_done("random");
      repeat ($urandom_range(0, 3)) @(negedge clk48);
    end

    repeat (4) @(negedge clk48);
    check("scoreboard_drained", exp_len.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
